// File: rtl/sva_window_checker.sv
// sva_window_checker: multi-thread monitor for the pattern trig |-> ##[MIN_DLY:MAX_DLY] ack.
// Each accepted trig occupies one slot of a NUM_THREADS pool until it passes or times out.
// Pass/fail/overflow are reported as one-cycle pulses and as saturating event counters.
module sva_window_checker #(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned MIN_DLY     = 1,
    parameter int unsigned MAX_DLY     = 8,
    parameter int unsigned ACK_SHARED  = 1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                               gclk,
    input  logic                               grst,
    input  logic                               en,
    input  logic                               clr,
    input  logic                               trig,
    input  logic                               ack,
    output logic                               busy,
    output logic                               pass,
    output logic                               fail,
    output logic                               overflow,
    output logic [$clog2(NUM_THREADS+1)-1:0]   active_cnt,
    output logic [CNT_WIDTH-1:0]               pass_cnt,
    output logic [CNT_WIDTH-1:0]               fail_cnt,
    output logic [CNT_WIDTH-1:0]               ovf_cnt
);

    localparam int unsigned AW = $clog2(NUM_THREADS + 1);
    localparam int unsigned IW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int unsigned SW = ((CNT_WIDTH > AW) ? CNT_WIDTH : AW) + 1;
    localparam logic [7:0]  MIN_AGE = 8'(MIN_DLY);
    localparam logic [7:0]  MAX_AGE = 8'(MAX_DLY);
    localparam logic [SW-1:0] CNT_MAX = {{(SW - CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};

    typedef enum logic {
        S_FREE = 1'b0,
        S_WAIT = 1'b1
    } slot_state_t;

    // Per-slot state: occupancy and edges elapsed since the trigger edge.
    slot_state_t r_state [NUM_THREADS];
    logic [7:0]  r_age   [NUM_THREADS];

    logic [NUM_THREADS-1:0] w_qual;
    logic [NUM_THREADS-1:0] w_pass_mask;
    logic [NUM_THREADS-1:0] w_fail_mask;
    logic                   w_oldest_vld;
    logic [IW-1:0]          w_oldest_idx;
    logic [7:0]             w_oldest_age;
    logic                   w_alloc_vld;
    logic [IW-1:0]          w_alloc_idx;
    logic                   w_do_alloc;
    logic                   w_ovf;
    logic [AW-1:0]          w_pass_num;
    logic [AW-1:0]          w_fail_num;
    logic [AW-1:0]          w_next_num;

    // Saturating accumulate of a per-edge event count into a statistics counter.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [AW-1:0]        b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (s > CNT_MAX) begin
            s = CNT_MAX;
        end
        return CNT_WIDTH'(s);
    endfunction

    // Find slots that see a qualifying ack and the oldest one among them.
    always_comb begin
        logic v_q;
        w_qual       = '0;
        w_oldest_vld = 1'b0;
        w_oldest_idx = '0;
        w_oldest_age = '0;
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            v_q = (r_state[i] == S_WAIT) && ack && (r_age[i] >= MIN_AGE);
            w_qual[i] = v_q;
            if (v_q && (!w_oldest_vld || (r_age[i] > w_oldest_age))) begin
                w_oldest_vld = 1'b1;
                w_oldest_idx = IW'(i);
                w_oldest_age = r_age[i];
            end
        end
    end

    // Decide which slots pass (shared or oldest-only ack) and which time out.
    always_comb begin
        logic v_p;
        w_pass_mask = '0;
        w_fail_mask = '0;
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            if (ACK_SHARED != 0) begin
                v_p = w_qual[i];
            end else begin
                v_p = w_oldest_vld && (w_oldest_idx == IW'(i));
            end
            w_pass_mask[i] = v_p;
            w_fail_mask[i] = (r_state[i] == S_WAIT) && !v_p && (r_age[i] == MAX_AGE);
        end
    end

    // Pick the lowest-index slot that is free before this edge; retiring slots are not reused yet.
    always_comb begin
        w_alloc_vld = 1'b0;
        w_alloc_idx = '0;
        for (int i = int'(NUM_THREADS) - 1; i >= 0; i--) begin
            if (r_state[i] == S_FREE) begin
                w_alloc_vld = 1'b1;
                w_alloc_idx = IW'(i);
            end
        end
        w_do_alloc = trig && en && w_alloc_vld;
        w_ovf      = trig && en && !w_alloc_vld;
    end

    // Count this edge's passes, failures and the post-edge occupancy.
    always_comb begin
        logic v_stay;
        logic v_new;
        w_pass_num = '0;
        w_fail_num = '0;
        w_next_num = '0;
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            v_stay = (r_state[i] == S_WAIT) && !w_pass_mask[i] && !w_fail_mask[i];
            v_new  = w_do_alloc && (w_alloc_idx == IW'(i));
            if (w_pass_mask[i]) begin
                w_pass_num = w_pass_num + AW'(1);
            end
            if (w_fail_mask[i]) begin
                w_fail_num = w_fail_num + AW'(1);
            end
            if (v_stay || v_new) begin
                w_next_num = w_next_num + AW'(1);
            end
        end
    end

    // Slot state machine: FREE -> WAIT on allocation, WAIT -> FREE on pass, timeout or clear.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            for (int i = 0; i < int'(NUM_THREADS); i++) begin
                r_state[i] <= S_FREE;
                r_age[i]   <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < int'(NUM_THREADS); i++) begin
                r_state[i] <= S_FREE;
                r_age[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_THREADS); i++) begin
                case (r_state[i])
                    S_FREE: begin
                        if (w_do_alloc && (w_alloc_idx == IW'(i))) begin
                            r_state[i] <= S_WAIT;
                            r_age[i]   <= 8'd1;
                        end
                    end
                    S_WAIT: begin
                        if (w_pass_mask[i] || w_fail_mask[i]) begin
                            r_state[i] <= S_FREE;
                            r_age[i]   <= '0;
                        end else begin
                            r_age[i]   <= r_age[i] + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Registered status, result pulses and saturating statistics.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            busy       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            overflow   <= 1'b0;
            active_cnt <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            ovf_cnt    <= '0;
        end else if (clr) begin
            busy       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            overflow   <= 1'b0;
            active_cnt <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            ovf_cnt    <= '0;
        end else begin
            busy       <= (w_next_num != '0);
            pass       <= (w_pass_mask != '0);
            fail       <= (w_fail_mask != '0);
            overflow   <= w_ovf;
            active_cnt <= w_next_num;
            pass_cnt   <= sat_add(pass_cnt, w_pass_num);
            fail_cnt   <= sat_add(fail_cnt, w_fail_num);
            ovf_cnt    <= sat_add(ovf_cnt, AW'(w_ovf));
        end
    end

endmodule
